// File: rtl/aes_kexp_pkg.sv
// Shared AES key-schedule definitions: mode/state encodings, per-mode sizes,
// S-box, xtime and the InvMixColumns helper used by the equivalent-inverse key path.
package aes_kexp_pkg;

  typedef enum logic [1:0] {
    MODE_128  = 2'b00,
    MODE_192  = 2'b01,
    MODE_256  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Entry 0 sits in the top byte so the table reads in the usual row order.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [5:0] nk_of(input mode_e m);
    case (m)
      MODE_192: nk_of = 6'd6;
      MODE_256: nk_of = 6'd8;
      default:  nk_of = 6'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input mode_e m);
    case (m)
      MODE_192: nr_of = 4'd12;
      MODE_256: nr_of = 4'd14;
      default:  nr_of = 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] nw_of(input mode_e m);
    case (m)
      MODE_192: nw_of = 6'd52;
      MODE_256: nw_of = 6'd60;
      default:  nw_of = 6'd44;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx  = 11'd2047 - {b, 3'b000};
    sbox = SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2   = xtime(b);
    x4   = xtime(x2);
    x8   = xtime(x4);
    gmul = (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    inv_mix_col = {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                   gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                   gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                   gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups, purely combinational.
module aes_sub_word
  import aes_kexp_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]), sbox(i_word[15:8]), sbox(i_word[7:0])};

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES-128/192/256 key schedule, WPC words per cycle into a 60-word store; start ignored unless IDLE.
// Round-key read latency is RD_REG cycles; KEY_EXP_EQINV_EN adds the equivalent-inverse round-key output.
module key_expansion_seq
  import aes_kexp_pkg::*;
#(
  parameter int WPC    = 1,
  parameter int RD_REG = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [255:0] i_key,
  input  logic [1:0]   i_mode,
  input  logic         i_start,
  input  logic [3:0]   i_rd_round,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic         o_key_valid,
  output logic [3:0]   o_nr,
  output logic [127:0] o_round_key
`ifdef KEY_EXP_EQINV_EN
  ,
  output logic [127:0] o_dec_round_key
`endif
);

  if (WPC != 1 && WPC != 2) begin : g_bad_wpc
    $error("key_expansion_seq: WPC must be 1 or 2");
  end

  state_e       r_state, w_state_nxt;
  mode_e        r_mode;
  logic [255:0] r_key;
  logic [31:0]  r_w [0:59];
  logic [5:0]   r_idx, r_imod;
  logic [7:0]   r_rcon;
  logic [3:0]   r_nr;
  logic         r_kv, r_err;

  logic         w_accept, w_reject, w_last, w_rot, w_sub_only;
  logic [5:0]   w_nk, w_imod_sum, w_imod_nxt;
  logic [31:0]  w_prev, w_sub_in, w_sub_out, w_temp, w_new0, w_new1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (mode_e'(i_mode) == MODE_RSVD) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        o_busy      = 1'b1;
        w_state_nxt = ST_EXPAND;
      end
      ST_EXPAND: begin
        o_busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_nk       = nk_of(r_mode);
  assign w_last     = (r_idx + 6'(WPC)) == nw_of(r_mode);
  assign w_prev     = r_w[r_idx - 6'd1];
  assign w_rot      = (r_imod == 6'd0);
  assign w_sub_only = (w_nk == 6'd8) && (r_imod == 6'd4);
  assign w_sub_in   = w_rot ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  assign w_temp = w_rot      ? (w_sub_out ^ {r_rcon, 24'h0}) :
                  w_sub_only ? w_sub_out : w_prev;
  assign w_new0 = r_w[r_idx - w_nk] ^ w_temp;
  // Nk is even, so the odd word of a pair is a plain XOR chain off the new even word.
  assign w_new1 = r_w[r_idx + 6'd1 - w_nk] ^ w_new0;

  assign w_imod_sum = r_imod + 6'(WPC);
  assign w_imod_nxt = (w_imod_sum >= w_nk) ? (w_imod_sum - w_nk) : w_imod_sum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode <= MODE_128;
      r_key  <= '0;
      r_idx  <= '0;
      r_imod <= '0;
      r_rcon <= '0;
      r_nr   <= '0;
      r_kv   <= 1'b0;
      r_err  <= 1'b0;
      for (int k = 0; k < 60; k++) r_w[k] <= '0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_mode <= mode_e'(i_mode);
        r_key  <= i_key;
        r_nr   <= nr_of(mode_e'(i_mode));
        r_kv   <= 1'b0;
      end
      if (r_state == ST_LOAD) begin
        for (int k = 0; k < 8; k++) begin
          if (6'(k) < w_nk) r_w[k] <= r_key[255 - 32*k -: 32];
        end
        r_idx  <= w_nk;
        r_imod <= '0;
        r_rcon <= RCON_INIT;
      end
      if (r_state == ST_EXPAND) begin
        r_w[r_idx] <= w_new0;
        if (WPC == 2) r_w[r_idx + 6'd1] <= w_new1;
        r_idx  <= r_idx + 6'(WPC);
        r_imod <= w_imod_nxt;
        if (w_rot) r_rcon <= xtime(r_rcon);
        if (w_last) r_kv <= 1'b1;
      end
    end
  end

  assign o_err       = r_err;
  assign o_key_valid = r_kv;
  assign o_nr        = r_nr;

  logic         w_rd_oor;
  logic [5:0]   w_rd_base;
  logic [127:0] w_rk_raw, w_rk;

  assign w_rd_oor  = i_rd_round > r_nr;
  assign w_rd_base = {i_rd_round, 2'b00};
  assign w_rk_raw  = {r_w[w_rd_base], r_w[w_rd_base + 6'd1], r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};
  assign w_rk      = w_rd_oor ? 128'h0 : w_rk_raw;

  if (RD_REG != 0) begin : g_rd_reg
    logic [127:0] r_rk;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_rk <= '0;
      else       r_rk <= w_rk;
    end
    assign o_round_key = r_rk;
  end else begin : g_rd_comb
    assign o_round_key = w_rk;
  end

`ifdef KEY_EXP_EQINV_EN
  logic [127:0] w_dk;

  // Inner rounds get InvMixColumns; first and last round keys pass through.
  always_comb begin
    w_dk = '0;
    if (!w_rd_oor) begin
      if (i_rd_round == 4'd0 || i_rd_round == r_nr) w_dk = w_rk_raw;
      else w_dk = {inv_mix_col(w_rk_raw[127:96]), inv_mix_col(w_rk_raw[95:64]),
                   inv_mix_col(w_rk_raw[63:32]),  inv_mix_col(w_rk_raw[31:0])};
    end
  end

  if (RD_REG != 0) begin : g_dk_reg
    logic [127:0] r_dk;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_dk <= '0;
      else       r_dk <= w_dk;
    end
    assign o_dec_round_key = r_dk;
  end else begin : g_dk_comb
    assign o_dec_round_key = w_dk;
  end
`endif

endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: a WPC=1/RD_REG=1 and a WPC=2/RD_REG=0 instance share stimulus;
// expected round keys are queued at job start and compared when each schedule completes.
module tb_key_expansion_seq;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic [255:0] i_key = '0;
  logic [1:0]   i_mode = 2'b00;
  logic         i_start = 1'b0;
  logic [3:0]   i_rd_round = 4'd0;

  logic         busy [2];
  logic         done [2];
  logic         err  [2];
  logic         kv   [2];
  logic [3:0]   nr   [2];
  logic [127:0] rk   [2];
`ifdef KEY_EXP_EQINV_EN
  logic [127:0] dk   [2];
`endif

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c_a5a5a5a5deadbeef0123456789abcdef;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b_5a5a5a5a5a5a5a5a;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 i_clk = ~i_clk;

  key_expansion_seq #(.WPC(1), .RD_REG(1)) u_dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_key(i_key), .i_mode(i_mode), .i_start(i_start),
    .i_rd_round(i_rd_round), .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]),
    .o_key_valid(kv[0]), .o_nr(nr[0]), .o_round_key(rk[0])
`ifdef KEY_EXP_EQINV_EN
    , .o_dec_round_key(dk[0])
`endif
  );

  key_expansion_seq #(.WPC(2), .RD_REG(0)) u_dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_key(i_key), .i_mode(i_mode), .i_start(i_start),
    .i_rd_round(i_rd_round), .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]),
    .o_key_valid(kv[1]), .o_nr(nr[1]), .o_round_key(rk[1])
`ifdef KEY_EXP_EQINV_EN
    , .o_dec_round_key(dk[1])
`endif
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [1:0] mode, input int wpc);
    int nk, nw;
    nk = (mode == 2'b01) ? 6 : (mode == 2'b10) ? 8 : 4;
    nw = (mode == 2'b01) ? 52 : (mode == 2'b10) ? 60 : 44;
    return 1 + (nw - nk) / wpc;
  endfunction

  task automatic start_job(input logic [1:0] mode, input logic [255:0] key);
    i_mode  = mode;
    i_key   = key;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Runs one accepted job to completion; restart_at > 0 injects a second start while busy.
  task automatic run_expand(input logic [1:0] mode, input logic [3:0] exp_nr, input int restart_at);
    int at  [2];
    int cnt [2];
    int lat [2];
    lat[0] = exp_lat(mode, 1);
    lat[1] = exp_lat(mode, 2);
    for (int d = 0; d < 2; d++) begin at[d] = -1; cnt[d] = 0; end
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == restart_at) begin
        i_mode = 2'b10; i_key = K256; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      if (n == 1) begin
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (busy[d] !== 1'b1 || kv[d] !== 1'b0)
            $display("FAIL load_state dut%0d busy=%b kv=%b want busy=1 kv=0", d, busy[d], kv[d]);
          else passed++;
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (done[d] === 1'b1) begin
          cnt[d]++;
          at[d] = n;
          checks++;
          if (kv[d] !== 1'b1 || busy[d] !== 1'b0 || nr[d] !== exp_nr)
            $display("FAIL done_flags dut%0d kv=%b busy=%b nr=%0d want kv=1 busy=0 nr=%0d",
                     d, kv[d], busy[d], nr[d], exp_nr);
          else passed++;
        end
      end
    end
    i_start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (at[d] != lat[d] || cnt[d] != 1)
        $display("FAIL done_timing dut%0d got cycle %0d pulses %0d want cycle %0d pulses 1",
                 d, at[d], cnt[d], lat[d]);
      else passed++;
      checks++;
      if (kv[d] !== 1'b1)
        $display("FAIL key_valid_hold dut%0d got %b want 1", d, kv[d]);
      else passed++;
    end
  endtask

  task automatic drain_reads();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      i_rd_round = e.rnd;
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rk[d] !== e.key)
          $display("FAIL round_key r%0d dut%0d got %h want %h", e.rnd, d, rk[d], e.key);
        else passed++;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy[d], done[d], err[d], kv[d], nr[d]} !== 8'h0 || rk[d] !== 128'h0)
        $display("FAIL %s dut%0d busy=%b done=%b err=%b kv=%b nr=%0d rk=%h want all 0",
                 name, d, busy[d], done[d], err[d], kv[d], nr[d], rk[d]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    #1 i_rst = 1'b1;
    tick(); tick();
    check_all_zero("reset_state");
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_aes128(input int restart_at);
    start_job(2'b00, K128);
    sb_q.push_back('{4'd0,  K128[255:128]});
    sb_q.push_back('{4'd1,  128'ha0fafe1788542cb123a339392a6c7605});
    sb_q.push_back('{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    sb_q.push_back('{4'd11, 128'h0});
    sb_q.push_back('{4'd15, 128'h0});
    run_expand(2'b00, 4'd10, restart_at);
    drain_reads();
  endtask

  task automatic test_aes192();
    start_job(2'b01, K192);
    sb_q.push_back('{4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5});
    sb_q.push_back('{4'd12, 128'he98ba06f448c773c8ecc720401002202});
    sb_q.push_back('{4'd13, 128'h0});
    run_expand(2'b01, 4'd12, 0);
    drain_reads();
  endtask

  task automatic test_aes256();
    start_job(2'b10, K256);
    sb_q.push_back('{4'd0,  K256[255:128]});
    sb_q.push_back('{4'd1,  K256[127:0]});
    sb_q.push_back('{4'd14, 128'hfe4890d1e6188d0b046df344706c631e});
    sb_q.push_back('{4'd15, 128'h0});
    run_expand(2'b10, 4'd14, 0);
    drain_reads();
  endtask

  task automatic test_reserved_mode();
    start_job(2'b11, K128);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (err[d] !== 1'b1 || busy[d] !== 1'b0)
        $display("FAIL err_pulse dut%0d err=%b busy=%b want err=1 busy=0", d, err[d], busy[d]);
      else passed++;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (err[d] !== 1'b0 || busy[d] !== 1'b0 || kv[d] !== 1'b1 || nr[d] !== 4'd14)
        $display("FAIL err_after dut%0d err=%b busy=%b kv=%b nr=%0d want 0 0 1 14",
                 d, err[d], busy[d], kv[d], nr[d]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_expand();
    int dn;
    dn = 0;
    start_job(2'b10, K256);
    for (int n = 1; n <= 11; n++) tick();
    i_rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    tick(); tick();
    i_rst = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      for (int d = 0; d < 2; d++) if (done[d] === 1'b1 || busy[d] === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) $display("FAIL no_done_after_reset got %0d active cycles want 0", dn);
    else passed++;
    check_all_zero("idle_after_reset");
  endtask

  initial begin
    test_reset();
    test_aes128(0);
    test_aes192();
    test_aes256();
    test_reserved_mode();
    test_reset_mid_expand();
    test_aes128(0);
    test_aes128(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
